// File: rtl/calculator_n.sv
// rtl/calculator_n.sv - parametrised BCD calculator driving a multiplexed 7-segment display
// Purpose: two NUM_DIGITS-digit BCD operands entered by increment buttons; add/sub/mul/div
//          through a multi-cycle restoring divider and a multi-cycle double-dabble converter.
// Ports:   clk        system clock, rising edge
//          rst        asynchronous active-low reset
//          button     per-digit increment buttons, A digits high, B digits low (MSD first)
//          operation  one-hot select: 1=add 2=sub 4=mul 8=div
//          ret        1 = show operands instead of the result
//          seg        active-low segments {dp,g,f,e,d,c,b,a}
//          an         active-low digit enables, one-hot-low
//          busy       computation in progress
// Option:  CALC_DIV_REMAINDER_EN - division shows quotient in the upper half, remainder in the lower half.
module calculator_n #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_DIGITS-1:0] button,
  input  logic [3:0]              operation,
  input  logic                    ret,
  output logic [7:0]              seg,
  output logic [2*NUM_DIGITS-1:0] an,
  output logic                    busy
);
  localparam int D    = 2*NUM_DIGITS;
  localparam int OPW  = $clog2(10**NUM_DIGITS);
  localparam int RW   = 2*OPW;
  localparam int NBCD = D + 1;          // RW bits can exceed D decimal digits
  localparam int DDW  = 4*NBCD + RW;
  localparam int KW   = 4*D + 4;
  localparam int CW   = $clog2(RW + 2);
  localparam int RCW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW   = $clog2(D);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_CONV, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d, rise;
  logic [4*D-1:0] digit_q, digit_d, result_q, result_d;
  logic [KW-1:0]  key, key_q, key_d, last_key_q, last_key_d;
  logic [OPW-1:0] a_bin, b_bin, opa_q, opa_d, opb_q, opb_d, quo_q, quo_d, rem_q, rem_d;
  logic [OPW:0]   trial;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DDW-1:0] dd_q, dd_d;
  logic [RW-1:0]  conv_val;
  logic           conv_neg, show_ops;
  logic           sign_q, sign_d, err_q, err_d, calc_sign_q, calc_sign_d, calc_err_q, calc_err_d;
  logic           busy_q, busy_d;
  logic [RCW-1:0] ref_q, ref_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [6:0]     pattern;
  logic [7:0]     seg_q, seg_d;
  logic [D-1:0]   an_q, an_d;

  function automatic logic [OPW-1:0] bcd2bin(input logic [4*NUM_DIGITS-1:0] bcd);
    logic [OPW-1:0] v;
    v = '0;
    for (int k = NUM_DIGITS-1; k >= 0; k--) v = v * OPW'(10) + OPW'(bcd[4*k +: 4]);
    return v;
  endfunction

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [DDW-1:0] dd_step(input logic [DDW-1:0] x);
    logic [DDW-1:0] y;
    y = x;
    for (int k = 0; k < NBCD; k++)
      if (y[RW+4*k +: 4] >= 4'd5) y[RW+4*k +: 4] = y[RW+4*k +: 4] + 4'd3;
    return {y[DDW-2:0], 1'b0};
  endfunction

  function automatic logic is_onehot(input logic [3:0] op);
    return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0100) || (op == 4'b1000);
  endfunction

  function automatic logic [6:0] seven_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Buttons: two-flop synchroniser, then a third flop for rising-edge detection.
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise    = sync2_q & ~sync3_q;
    digit_d = digit_q;
    for (int i = 0; i < D; i++)
      if (rise[i]) digit_d[4*i +: 4] = (digit_q[4*i +: 4] >= 4'd9) ? 4'd0 : digit_q[4*i +: 4] + 4'd1;
  end

  assign a_bin = bcd2bin(digit_q[4*D-1:4*NUM_DIGITS]);
  assign b_bin = bcd2bin(digit_q[4*NUM_DIGITS-1:0]);
  assign key   = {digit_q, operation};

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    last_key_d  = last_key_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    dd_d        = dd_q;
    result_d    = result_q;
    sign_d      = sign_q;
    err_d       = err_q;
    calc_sign_d = calc_sign_q;
    calc_err_d  = calc_err_q;
    busy_d      = busy_q;
    trial       = {rem_q, quo_q[OPW-1]};
    conv_neg    = (key_q[3:0] == 4'b0010) && (opa_q < opb_q);
    case (key_q[3:0])
      4'b0001: conv_val = RW'(opa_q) + RW'(opb_q);
      4'b0010: conv_val = conv_neg ? RW'(opb_q - opa_q) : RW'(opa_q - opb_q);
      4'b0100: conv_val = RW'(opa_q) * RW'(opb_q);
`ifdef CALC_DIV_REMAINDER_EN
      4'b1000: conv_val = RW'(quo_q) * RW'(10**NUM_DIGITS) + RW'(rem_q);
`else
      4'b1000: conv_val = RW'(quo_q);
`endif
      default: conv_val = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (key != last_key_q) begin
          key_d       = key;
          opa_d       = a_bin;
          opb_d       = b_bin;
          quo_d       = a_bin;   // dividend shifts out of the quotient register
          rem_d       = '0;
          cnt_d       = '0;
          calc_sign_d = 1'b0;
          calc_err_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = (operation == 4'b1000) ? S_DIV : S_CONV;
        end
      end
      S_DIV: begin
        if (opb_q == '0) begin
          calc_err_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_CONV;
        end else begin
          if (trial >= {1'b0, opb_q}) begin
            rem_d = OPW'(trial - {1'b0, opb_q});
            quo_d = {quo_q[OPW-2:0], 1'b1};
          end else begin
            rem_d = trial[OPW-1:0];
            quo_d = {quo_q[OPW-2:0], 1'b0};
          end
          if (cnt_q == CW'(OPW-1)) begin
            cnt_d   = '0;
            state_d = S_CONV;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CONV: begin
        // Count 0 loads the arithmetic result; counts 1..RW are the shift steps.
        if (cnt_q == '0) begin
          dd_d        = {{(4*NBCD){1'b0}}, conv_val};
          calc_sign_d = conv_neg;
        end else begin
          dd_d = dd_step(dd_q);
        end
        if (cnt_q == CW'(RW)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (is_onehot(key_q[3:0])) begin
          result_d = dd_q[RW +: 4*D];
          sign_d   = calc_sign_q;
          err_d    = calc_err_q;
        end
        last_key_d = key_q;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ref_d = ref_q + RCW'(1);
    idx_d = idx_q;
    if (ref_q == RCW'(REFRESH_DIV-1)) begin
      ref_d = '0;
      idx_d = (idx_q == IW'(D-1)) ? '0 : idx_q + IW'(1);
    end
    show_ops = ret || !is_onehot(operation);
    if (show_ops)                             pattern = seven_seg(digit_q[4*idx_q +: 4]);
    else if (err_q)                           pattern = (idx_q == IW'(D-1)) ? 7'h06 : 7'h7F;
    else if (sign_q && (idx_q == IW'(D-1)))   pattern = 7'h3F;
    else                                      pattern = seven_seg(result_q[4*idx_q +: 4]);
    seg_d = {1'b1, pattern};
    an_d  = ~(D'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sync3_q     <= '0;
      digit_q     <= '0;
      key_q       <= '0;
      last_key_q  <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      dd_q        <= '0;
      result_q    <= '0;
      sign_q      <= 1'b0;
      err_q       <= 1'b0;
      calc_sign_q <= 1'b0;
      calc_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      ref_q       <= '0;
      idx_q       <= '0;
      seg_q       <= 8'hFF;
      an_q        <= '1;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync3_q     <= sync3_d;
      digit_q     <= digit_d;
      key_q       <= key_d;
      last_key_q  <= last_key_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      dd_q        <= dd_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      err_q       <= err_d;
      calc_sign_q <= calc_sign_d;
      calc_err_q  <= calc_err_d;
      busy_q      <= busy_d;
      ref_q       <= ref_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_calculator_n.sv
// tb/tb_calculator_n.sv - self-checking bench for calculator_n (NUM_DIGITS=2, REFRESH_DIV=4)
module tb_calculator_n;
  localparam int ND   = 2;
  localparam int D    = 4;
  localparam int RDIV = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [D-1:0] button = '0;
  logic [3:0]   operation = 4'd0;
  logic         ret = 1'b0;
  logic [7:0]   seg;
  logic [D-1:0] an;
  logic         busy;

  calculator_n #(.NUM_DIGITS(ND), .REFRESH_DIV(RDIV)) dut (
    .clk(clk), .rst(rst), .button(button), .operation(operation),
    .ret(ret), .seg(seg), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  // Display codes per digit: 0-9 digits, A = minus, E = 'E', F = blank.
  typedef struct { int a; int b; logic [3:0] op; logic rt; logic [15:0] disp; int lat; } vec_t;
  typedef struct { logic [15:0] disp; int lat; } exp_t;

`ifdef CALC_DIV_REMAINDER_EN
  localparam logic [15:0] DIV_9999 = 16'h0100;
  localparam logic [15:0] DIV_9998 = 16'h0101;
  localparam logic [15:0] DIV_3298 = 16'h0032;
  localparam logic [15:0] DIV_5007 = 16'h0701;
`else
  localparam logic [15:0] DIV_9999 = 16'h0001;
  localparam logic [15:0] DIV_9998 = 16'h0001;
  localparam logic [15:0] DIV_3298 = 16'h0000;
  localparam logic [15:0] DIV_5007 = 16'h0007;
`endif

  vec_t  vecs[15];
  exp_t  sb_q[$];
  exp_t  e;
  int    n_pass = 0;
  int    n_total = 0;
  int    model_a = 0;
  int    model_b = 0;
  int    lat;
  int    cnt;
  logic [31:0] s;

  function automatic logic [7:0] seg_of(input logic [3:0] c);
    case (c)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'hBF;
      4'hE: return 8'h86;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] segs_of(input logic [15:0] codes);
    logic [31:0] r;
    for (int i = 0; i < D; i++) r[8*i +: 8] = seg_of(codes[4*i +: 4]);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp_v);
  endtask

  task automatic press(input logic [D-1:0] mask);
    @(negedge clk); button = mask;
    repeat (2) @(negedge clk);
    button = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < 400) begin
      @(negedge clk);
      if (busy) quiet = 0; else quiet++;
      n++;
    end
    if (quiet < 4) begin
      n_total++;
      $display("FAIL settle: busy still active after %0d cycles, required idle", n);
    end
  endtask

  task automatic wait_low();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_total++;
      $display("FAIL wait_low: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic set_operands(input int a, input int b);
    int tgt[4];
    int cur[4];
    int p[4];
    logic [D-1:0] mask;
    @(negedge clk); operation = 4'd0;
    tgt[3] = a / 10; tgt[2] = a % 10; tgt[1] = b / 10; tgt[0] = b % 10;
    cur[3] = model_a / 10; cur[2] = model_a % 10; cur[1] = model_b / 10; cur[0] = model_b % 10;
    for (int i = 0; i < D; i++) p[i] = (tgt[i] - cur[i] + 10) % 10;
    for (int k = 0; k < 9; k++) begin
      mask = '0;
      for (int i = 0; i < D; i++) if (p[i] > 0) begin mask[i] = 1'b1; p[i]--; end
      if (mask != '0) press(mask);
    end
    model_a = a;
    model_b = b;
    settle();
  endtask

  task automatic measure(output int l);
    l = 0;
    @(negedge clk);
    while (busy && l < 200) begin
      l++;
      @(negedge clk);
    end
  endtask

  task automatic read_display(output logic [31:0] r);
    r = '0;
    repeat (D*RDIV + 1) begin
      @(negedge clk);
      for (int i = 0; i < D; i++) if (an == ~(4'b0001 << i)) r[8*i +: 8] = seg;
    end
  endtask

  initial begin
    vecs[0]  = '{99, 99, 4'd0, 1'b0, 16'h9999, -1};
    vecs[1]  = '{99, 99, 4'd4, 1'b0, 16'h9801, 16};
    vecs[2]  = '{99, 99, 4'd1, 1'b0, 16'h0198, 16};
    vecs[3]  = '{99, 99, 4'd2, 1'b0, 16'h0000, 16};
    vecs[4]  = '{99, 99, 4'd8, 1'b0, DIV_9999, 23};
    vecs[5]  = '{99, 98, 4'd0, 1'b1, 16'h9998, -1};
    vecs[6]  = '{99, 98, 4'd2, 1'b0, 16'h0001, 16};
    vecs[7]  = '{99, 98, 4'd8, 1'b0, DIV_9998, 23};
    vecs[8]  = '{32, 98, 4'd2, 1'b0, 16'hA066, 16};
    vecs[9]  = '{32, 98, 4'd8, 1'b0, DIV_3298, 23};
    vecs[10] = '{32,  0, 4'd8, 1'b0, 16'hEFFF, 17};
    vecs[11] = '{32,  0, 4'd8, 1'b1, 16'h3200, 17};
    vecs[12] = '{ 7,  5, 4'd1, 1'b0, 16'h0012, 16};
    vecs[13] = '{12, 34, 4'd4, 1'b0, 16'h0408, 16};
    vecs[14] = '{50,  7, 4'd8, 1'b0, DIV_5007, 23};

    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset seg", {24'd0, seg}, 32'h0000_00FF);
    check("reset an", {28'd0, an}, 32'h0000_000F);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      set_operands(vecs[i].a, vecs[i].b);
      @(negedge clk);
      ret = vecs[i].rt;
      operation = vecs[i].op;
      e.disp = vecs[i].disp;
      e.lat  = vecs[i].lat;
      sb_q.push_back(e);
      lat = -1;
      if (vecs[i].lat >= 0) measure(lat); else settle();
      e = sb_q.pop_front();
      if (e.lat >= 0) check($sformatf("vec%0d latency", i), lat, e.lat);
      read_display(s);
      check($sformatf("vec%0d display", i), s, segs_of(e.disp));
    end

    // Held button increments once; simultaneous edges both apply.
    @(negedge clk); ret = 1'b0; operation = 4'd0;
    settle();
    @(negedge clk); button = 4'b1000;
    repeat (20) @(negedge clk);
    button = '0;
    settle();
    e.disp = 16'h6007; e.lat = -1; sb_q.push_back(e);
    read_display(s);
    e = sb_q.pop_front();
    check("held button", s, segs_of(e.disp));
    press(4'b1010);
    settle();
    e.disp = 16'h7017; e.lat = -1; sb_q.push_back(e);
    read_display(s);
    e = sb_q.pop_front();
    check("dual pulse", s, segs_of(e.disp));
    model_a = 70;
    model_b = 17;

    // Operation change while busy: subtraction shows first, then division.
    set_operands(32, 98);
    @(negedge clk); ret = 1'b0; operation = 4'd2;
    e.disp = 16'hA066; e.lat = -1; sb_q.push_back(e);
    e.disp = DIV_3298; e.lat = -1; sb_q.push_back(e);
    repeat (5) @(negedge clk);
    operation = 4'd8;
    wait_low();
    read_display(s);
    e = sb_q.pop_front();
    check("midchange sub", s, segs_of(e.disp));
    wait_low();
    read_display(s);
    e = sb_q.pop_front();
    check("midchange div", s, segs_of(e.disp));
    check("scoreboard empty", sb_q.size(), 32'd0);

    // Reset in the middle of a division.
    @(negedge clk); operation = 4'd0;
    settle();
    @(negedge clk); operation = 4'd8;
    repeat (5) @(negedge clk);
    check("busy in div", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort seg", {24'd0, seg}, 32'h0000_00FF);
    check("abort an", {28'd0, an}, 32'h0000_000F);
    operation = 4'd0;
    ret = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_a = 0;
    model_b = 0;
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("no compute after reset", cnt, 32'd0);
    read_display(s);
    check("digits cleared", s, segs_of(16'h0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/calculator_n.md
Name: calculator_n

Overview:
- Parametrised successor to the team's 2+2-digit BCD calculator.
- Two operands of NUM_DIGITS decimal digits each, entered with per-digit increment buttons.
- One-hot operation select (add/sub/mul/div); results come from a multi-cycle divider and a multi-cycle binary-to-BCD converter.
- Drives a time-multiplexed 7-segment display of 2*NUM_DIGITS digits. Sits between board buttons/switches and the display pins.

Parameters:
- NUM_DIGITS, 2, decimal digits per operand (1..4). Display width D = 2*NUM_DIGITS.
- REFRESH_DIV, 50000, clk cycles each display digit is enabled. Must be at least 1.
- Derived: OPW = clog2(10^NUM_DIGITS) operand binary width; RW = 2*OPW result width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- button  in  D  increment buttons. Bits D-1..NUM_DIGITS are operand A digits (MSD first); bits NUM_DIGITS-1..0 are operand B digits.
- operation  in  4  one-hot operation select: 1=add, 2=sub, 4=mul, 8=div.
- ret  in  1  when 1, display the operands instead of the result.
- seg  out  8  active-low segments. Bit 7 = dp (always 1); bits 6..0 = g,f,e,d,c,b,a.
- an  out  D  active-low digit enables, one-hot-low.
- busy  out  1  high while a computation is in progress.

Behaviour:
- Reset (rst=0, async):
  - all digits 0, result register = 0000…, FSM IDLE, busy=0;
  - seg=8'hFF, an=all 1s, refresh counter and digit index 0.
- Buttons:
  - each bit passes through a 2-flop synchroniser, then rising-edge detection;
  - one rising edge increments that digit once, wrapping 9→0;
  - held buttons do not repeat; simultaneous edges on several bits all apply in the same cycle;
  - the digit updates 3 clk cycles after the input edge.
- Operand value: binary value of each operand is computed combinationally from its BCD digits (OPW bits).
- Request key = {A digits, B digits, operation}.
- FSM states:
  - IDLE: if key differs from the last computed key, latch the key and operands, set busy=1, then go to DIV if operation==8, else CONV.
    - add/sub/mul are evaluated on entry to CONV.
    - sub yields a sign flag plus magnitude |A-B|.
  - DIV: restoring divider, exactly OPW cycles, giving quotient and remainder. If B==0, set the error flag and skip the division cycles (go to CONV next cycle).
  - CONV: double-dabble over RW bits, exactly RW cycles.
  - DONE: one cycle. Result register, sign and error flags update; busy=0; latched key becomes the last computed key; return to IDLE.
- Key changes during busy are ignored until IDLE, then recomputed. An invalid operation (0 or more than one bit set) completes with no result update.
- Latency from latched key to result update:
  - add/sub/mul: RW+2 cycles (16 for NUM_DIGITS=2);
  - div: OPW+RW+2 cycles (23).
- Display content, digit index i (0 = rightmost):
  - ret=1, or operation not one-hot: show the A digits then the B digits.
  - otherwise: show the D low BCD digits of the result, leading zeros shown.
  - sub negative: digit D-1 shows minus (only g lit). Magnitude is at most 10^NUM_DIGITS-1, so it never collides with the sign digit.
  - div, B=0: digit D-1 shows 'E' (a,d,e,f,g lit); all other digits blank (7'h7F).
  - mul: product fits in D digits exactly, so no overflow case exists.
  - div (default): quotient, right-aligned.
- Display timing:
  - the display shows the registered result only; during busy the previous result stays displayed;
  - refresh counter counts 0..REFRESH_DIV-1, then advances the digit index 0→D-1→0;
  - an[i]=0 only for the current index; seg is registered in the same cycle as an.
- Reset during busy aborts the computation immediately. After release the FSM starts fresh from IDLE; with all-zero operands and operation 0, no computation is triggered.

Optional Feature:
- Macro: CALC_DIV_REMAINDER_EN.
- Defined: for division, the upper NUM_DIGITS digits show the quotient and the lower NUM_DIGITS digits show the remainder (quotient fits because quotient ≤ A).
- Undefined: the quotient alone is shown right-aligned and the remainder logic is removed.

Test Plan (NUM_DIGITS=2, REFRESH_DIV=4):
- Reset, then press all 4 buttons 9 times → display 9999. op=4 → 9801 after 16 cycles. op=1 → 0198. op=2 → 0000. op=8 → 0001, or 0100 with the macro defined.
- From 9999, ret=1, press button[0] 9 times → B=98, display 9998. ret=0, op=2 → 0001. op=8 → 0001 (0101 with macro) after 23 cycles; busy high for exactly 23 cycles.
- A=32, B=98, op=2 → display "-066". op=8 → 0000 (0032 with macro).
- B=00, op=8 → digit 3 shows 'E' (seg 8'h86), digits 2..0 blank. ret=1 → 3200.
- Hold button[3] high for 20 cycles → A MSD increments exactly once. Pulse button[3] and button[1] in the same cycle → both digits increment.
- Change op from 2 to 8 mid-computation → subtraction result appears first, then the division result. Assert rst mid-DIV → busy=0, seg=8'hFF, an=4'hF, all digits 0.
